// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU sequencer: ALU op codes, instruction
// opcodes, instruction field positions and the FSM state encoding.
package alu_seq_pkg;

  localparam int unsigned DataW  = 8;
  localparam int unsigned NRegs  = 4;
  localparam int unsigned InstrW = 15;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluNot = 2'b11;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpNot  = 3'b011;
  localparam logic [2:0] OpLdi  = 3'b100;
  localparam logic [2:0] OpAddi = 3'b101;
  localparam logic [2:0] OpTst  = 3'b110;
  localparam logic [2:0] OpRsv  = 3'b111;

  localparam int unsigned OpMsb  = 14;
  localparam int unsigned OpLsb  = 12;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 10;
  localparam int unsigned RsMsb  = 9;
  localparam int unsigned RsLsb  = 8;
  localparam int unsigned ImmMsb = 7;
  localparam int unsigned ImmLsb = 0;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write port,
// all entries cleared by the asynchronous active-low reset.
module alu_seq_regfile #(
  parameter int unsigned DataW = 8,
  parameter int unsigned NRegs = 4,
  localparam int unsigned AddrW = $clog2(NRegs)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] rd_addr_i,
  input  logic [AddrW-1:0] rs_addr_i,
  output logic [DataW-1:0] rd_data_o,
  output logic [DataW-1:0] rs_data_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i
);

  logic [DataW-1:0] regs_q [NRegs];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_data_o = regs_q[rd_addr_i];
  assign rs_data_o = regs_q[rs_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Serial instruction sequencer around an external 8-bit combinational ALU:
// accept, execute for one cycle with write-back, then hold the response.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned NREGS  = NRegs
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [InstrW-1:0] in_instr,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_err
);

  state_e state_q, state_d;

  logic [InstrW-1:0] instr_q;
  logic [2:0]        op;
  logic [1:0]        rd, rs;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rd_data, rs_data;

  logic              exec;
  logic              we;
  logic              is_arith;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] result_d;
  logic              zero_d, ovf_d, err_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_result_q;
  logic              out_zero_q, out_ovf_q, out_err_q;

  assign op   = instr_q[OpMsb:OpLsb];
  assign rd   = instr_q[RdMsb:RdLsb];
  assign rs   = instr_q[RsMsb:RsLsb];
  assign imm  = instr_q[ImmMsb:ImmLsb];
  assign exec = (state_q == StExec);

  assign in_ready = (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_ready && in_valid) instr_q <= in_instr;
    end
  end

  alu_seq_regfile #(
    .DataW (DATA_W),
    .NRegs (NREGS)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rd_addr_i (rd),
    .rs_addr_i (rs),
    .rd_data_o (rd_data),
    .rs_data_o (rs_data),
    .we_i      (we),
    .waddr_i   (rd),
    .wdata_i   (alu_result)
  );

  // ALU is driven only while executing; idle/response cycles present zeros.
  always_comb begin
    alu_op = AluAdd;
    alu_a  = '0;
    alu_b  = '0;
    if (exec) begin
      case (op)
        OpAdd:   begin alu_op = AluAdd; alu_a = rd_data; alu_b = rs_data; end
        OpSub:   begin alu_op = AluSub; alu_a = rd_data; alu_b = rs_data; end
        OpAnd:   begin alu_op = AluAnd; alu_a = rd_data; alu_b = rs_data; end
        OpNot:   begin alu_op = AluNot; alu_a = rd_data; alu_b = rs_data; end
        OpLdi:   begin alu_op = AluAdd; alu_a = '0;      alu_b = imm;     end
        OpAddi:  begin alu_op = AluAdd; alu_a = rd_data; alu_b = imm;     end
        OpTst:   begin alu_op = AluAdd; alu_a = rd_data; alu_b = '0;      end
        default: begin alu_op = AluAdd; alu_a = '0;      alu_b = '0;      end
      endcase
    end
  end

  assign we       = exec && (op != OpTst) && (op != OpRsv);
  assign is_arith = (op == OpAdd) || (op == OpSub) || (op == OpAddi);
  assign b_eff    = (op == OpSub) ? ~alu_b : alu_b;

  always_comb begin
    err_d    = (op == OpRsv);
    result_d = err_d ? '0 : alu_result;
    ovf_d    = is_arith && (alu_a[DATA_W-1] == b_eff[DATA_W-1]) &&
               (alu_result[DATA_W-1] != alu_a[DATA_W-1]);
    if (err_d) begin
      zero_d = 1'b1;
    end else if (op == OpTst) begin
      zero_d = alu_zero;
    end else begin
      zero_d = (alu_result == '0);
    end
  end

  // Response payload only changes on the EXEC->RESP edge; valid drops on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_err_q    <= 1'b0;
    end else if (exec) begin
      out_valid_q  <= 1'b1;
      out_result_q <= result_d;
      out_zero_q   <= zero_d;
      out_ovf_q    <= ovf_d;
      out_err_q    <= err_d;
    end else if ((state_q == StResp) && out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_ovf    = out_ovf_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized checks of alu_sequencer against an arithmetic
// reference model of the instruction set and a behavioural ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_instr = '0;
  logic [1:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_result;
  logic        out_zero, out_ovf, out_err;

  int n_cmp = 0;
  int n_err = 0;
  int regs [4];
  logic [7:0] last_res;
  logic       last_zero, last_ovf, last_err;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU standing in for the external instance.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = ~alu_b;
    endcase
    alu_zero = (alu_a == 8'h00);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Issue one instruction from IDLE, check EXEC drive, response and hold, then retire it.
  task automatic issue(input int op, input int rd, input int rs, input int imm, input int hold);
    int ra, rb, eop, ea, eb, er, ez, eo, ee, s;
    bit wr;
    ra = regs[rd];
    rb = regs[rs];
    eop = 0; ea = 0; eb = 0; er = 0; eo = 0; ee = 0; wr = 1'b1;
    case (op)
      0: begin eop = 0; ea = ra; eb = rb; er = (ra + rb) % 256;
               s = sx(ra) + sx(rb); eo = int'(s > 127 || s < -128); end
      1: begin eop = 1; ea = ra; eb = rb; er = (ra - rb + 256) % 256;
               s = sx(ra) - sx(rb); eo = int'(s > 127 || s < -128); end
      2: begin eop = 2; ea = ra; eb = rb; er = ra & rb; end
      3: begin eop = 3; ea = ra; eb = rb; er = 255 - rb; end
      4: begin eb = imm; er = imm; end
      5: begin ea = ra; eb = imm; er = (ra + imm) % 256;
               s = sx(ra) + sx(imm); eo = int'(s > 127 || s < -128); end
      6: begin ea = ra; er = ra; wr = 1'b0; end
      default: begin ee = 1; er = 0; wr = 1'b0; end
    endcase
    ez = int'(er == 0);

    @(negedge clk);
    check(in_ready, 1, "in_ready_idle");
    in_instr = 15'((op << 12) | (rd << 10) | (rs << 8) | imm);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = 15'($urandom);
    check(in_ready, 0, "in_ready_exec");
    check(out_valid, 0, "out_valid_exec");
    check(alu_op, eop, "alu_op");
    check(alu_a, ea, "alu_a");
    check(alu_b, eb, "alu_b");
    @(negedge clk);
    check(out_valid, 1, "out_valid_resp");
    check(out_result, er, "out_result");
    check(out_zero, ez, "out_zero");
    check(out_ovf, eo, "out_ovf");
    check(out_err, ee, "out_err");
    check(in_ready, 0, "in_ready_resp");
    check({alu_op, alu_a, alu_b}, 0, "alu_idle_drive");
    last_res = out_result; last_zero = out_zero; last_ovf = out_ovf; last_err = out_err;
    if (wr) regs[rd] = er;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_instr = 15'($urandom);
      @(negedge clk);
      check(out_valid, 1, "hold_valid");
      check(in_ready, 0, "hold_in_ready");
      check(out_result, er, "hold_result");
      check({out_zero, out_ovf, out_err}, {ez[0], eo[0], ee[0]}, "hold_flags");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check(out_valid, 0, "out_valid_done");
    check(in_ready, 1, "in_ready_back");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) regs[i] = 0;

    // Reset state
    #12;
    check(out_valid, 0, "rst_out_valid");
    check(in_ready, 1, "rst_in_ready");
    check({out_result, out_zero, out_ovf, out_err}, 0, "rst_outputs");
    check({alu_op, alu_a, alu_b}, 0, "rst_alu_drive");
    @(negedge clk);
    rst_n = 1'b1;

    // Signed overflow on ADD
    issue(4, 1, 0, 8'h7F, 0);
    check(last_res, 8'h7F, "ldi_r1");
    issue(4, 2, 0, 8'h01, 0);
    check(last_res, 8'h01, "ldi_r2");
    issue(0, 1, 2, 0, 0);
    check({last_res, last_ovf, last_zero}, {8'h80, 1'b1, 1'b0}, "add_ovf");

    // SUB to zero with rd == rs, then TST leaves r0 alone
    issue(4, 0, 0, 8'h05, 0);
    issue(1, 0, 0, 0, 0);
    check({last_res, last_zero, last_ovf}, {8'h00, 1'b1, 1'b0}, "sub_self");
    issue(6, 0, 0, 0, 0);
    check({last_res, last_zero}, {8'h00, 1'b1}, "tst_r0");

    // NOT / AND / ADDI wrap
    issue(4, 3, 0, 8'hF0, 0);
    issue(3, 3, 3, 0, 0);
    check(last_res, 8'h0F, "not_r3");
    issue(2, 3, 2, 0, 0);
    check(last_res, 8'h01, "and_r3");
    issue(5, 3, 0, 8'hFF, 0);
    check({last_res, last_ovf, last_zero}, {8'h00, 1'b0, 1'b1}, "addi_wrap");

    // Reserved opcode, registers unchanged
    issue(7, 1, 2, 8'hAB, 0);
    check({last_err, last_res, last_zero}, {1'b1, 8'h00, 1'b1}, "reserved");
    for (int r = 0; r < 4; r++) issue(6, r, 0, 0, 0);

    // Backpressure with a competing in_valid
    issue(4, 0, 0, 8'h3C, 5);
    issue(6, 0, 0, 0, 0);
    check(last_res, 8'h3C, "hold_no_accept");

    // Reset during EXEC of ADDI r1,0x10
    @(negedge clk);
    in_instr = 15'((5 << 12) | (1 << 10) | 8'h10);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({alu_op, alu_a, alu_b}, {2'b00, 8'h80, 8'h10}, "exec_before_rst");
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) regs[i] = 0;
    #1;
    check(out_valid, 0, "rst_exec_valid");
    check({alu_op, alu_a, alu_b}, 0, "rst_exec_drive");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check(out_valid, 0, "no_resp_after_rst");
    end
    issue(6, 1, 0, 0, 0);
    check({last_res, last_zero}, {8'h00, 1'b1}, "r1_cleared");

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
